vga_timing_gen: RTL and testbench

Upstream VGA timing stage for the 640x480 display path. Generates the pixel scan coordinates pixelX/pixelY that feed the background drawer and the object drawers. Samples the final 8-bit pixel colour returned by the downstream mux and drives the monitor pins (hsync, vsync, 4-bit R/G/B) with sync delayed to match the drawing pipeline latency. Also provides the per-frame pulse used by game logic.

---
 rtl/vga_timing_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 155 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Scan/pixel bus between the VGA timing generator and the drawing pipeline,
// plus the monitor pins it drives.
interface vga_timing_if;
    logic [7:0]  RGBIn;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        pixelTick;
    logic        startOfFrame;
    logic        vgaHS;
    logic        vgaVS;
    logic        blankN;
    logic [3:0]  vgaR;
    logic [3:0]  vgaG;
    logic [3:0]  vgaB;

    modport master (
        input  RGBIn,
        output pixelX, pixelY, pixelTick, startOfFrame,
        output vgaHS, vgaVS, blankN, vgaR, vgaG, vgaB
    );

    modport slave (
        output RGBIn,
        input  pixelX, pixelY, pixelTick, startOfFrame,
        input  vgaHS, vgaVS, blankN, vgaR, vgaG, vgaB
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA scan timing: pixel divider, X/Y scan counters, sync/blank decode delayed to
// match the drawing pipeline, and registered colour expansion onto the DAC pins.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CLK_DIV    = 2,
    parameter int PIPE_DELAY = 1
) (
    input  logic         clk,
    input  logic         resetN,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [1:0]  DIV_LAST = 2'(CLK_DIV - 1);

    logic [1:0]  divCnt;
    logic        pixelTick;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;

    logic        tickNext;
    logic        sofNext;
    logic [10:0] xNext;
    logic [10:0] yNext;
    logic        hsRaw;
    logic        vsRaw;
    logic        visRaw;

    logic [PIPE_DELAY-1:0] hsPipe;
    logic [PIPE_DELAY-1:0] vsPipe;
    logic [PIPE_DELAY-1:0] visPipe;

    logic       vgaHS;
    logic       vgaVS;
    logic       blankN;
    logic [3:0] vgaR;
    logic [3:0] vgaG;
    logic [3:0] vgaB;

    logic [1:0] blueIn;
    logic [2:0] redIn;
    logic [2:0] greenIn;

    assign blueIn  = vga.RGBIn[7:6];
    assign redIn   = vga.RGBIn[5:3];
    assign greenIn = vga.RGBIn[2:0];

    // pixelTick is registered, so it is computed from the divider value one clk
    // ahead; the first strobe therefore lands CLK_DIV clks after reset release.
    always_comb begin
        tickNext = (divCnt == DIV_LAST);
        xNext    = pixelX;
        yNext    = pixelY;
        if (pixelTick) begin
            if (pixelX == H_LAST) begin
                xNext = '0;
                yNext = (pixelY == V_LAST) ? '0 : pixelY + 11'd1;
            end else begin
                xNext = pixelX + 11'd1;
            end
        end
        sofNext = tickNext && (xNext == H_LAST) && (yNext == V_LAST);
        hsRaw   = !((pixelX >= HS_START) && (pixelX < HS_END));
        vsRaw   = !((pixelY >= VS_START) && (pixelY < VS_END));
        visRaw  = (pixelX < H_VIS) && (pixelY < V_VIS);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            divCnt       <= '0;
            pixelTick    <= 1'b0;
            startOfFrame <= 1'b0;
            pixelX       <= '0;
            pixelY       <= '0;
        end else begin
            divCnt       <= (divCnt == DIV_LAST) ? 2'd0 : divCnt + 2'd1;
            pixelTick    <= tickNext;
            startOfFrame <= sofNext;
            pixelX       <= xNext;
            pixelY       <= yNext;
        end
    end

    // Sync/visible flags ride alongside the drawers' latency, one stage per tick.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hsPipe  <= '1;
            vsPipe  <= '1;
            visPipe <= '0;
        end else if (pixelTick) begin
            hsPipe[0]  <= hsRaw;
            vsPipe[0]  <= vsRaw;
            visPipe[0] <= visRaw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hsPipe[i]  <= hsPipe[i-1];
                vsPipe[i]  <= vsPipe[i-1];
                visPipe[i] <= visPipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vgaHS  <= 1'b1;
            vgaVS  <= 1'b1;
            blankN <= 1'b0;
            vgaR   <= '0;
            vgaG   <= '0;
            vgaB   <= '0;
        end else if (pixelTick) begin
            vgaHS  <= hsPipe[PIPE_DELAY-1];
            vgaVS  <= vsPipe[PIPE_DELAY-1];
            blankN <= visPipe[PIPE_DELAY-1];
            if (visPipe[PIPE_DELAY-1]) begin
                vgaR <= {redIn, redIn[2]};
                vgaG <= {greenIn, greenIn[2]};
                vgaB <= {blueIn, blueIn};
            end else begin
                vgaR <= '0;
                vgaG <= '0;
                vgaB <= '0;
            end
        end
    end

    assign vga.pixelX       = pixelX;
    assign vga.pixelY       = pixelY;
    assign vga.pixelTick    = pixelTick;
    assign vga.startOfFrame = startOfFrame;
    assign vga.vgaHS        = vgaHS;
    assign vga.vgaVS        = vgaVS;
    assign vga.blankN       = blankN;
    assign vga.vgaR         = vgaR;
    assign vga.vgaG         = vgaG;
    assign vga.vgaB         = vgaB;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing (line level), a
// CLK_DIV=1/PIPE_DELAY=3 alignment instance, and a tiny-raster frame-level instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA;
    logic rstB;
    logic rstC;

    vga_timing_if ifA ();
    vga_timing_if ifB ();
    vga_timing_if ifC ();

    vga_timing_gen #(.CLK_DIV(2), .PIPE_DELAY(1)) dutA (
        .clk(clk), .resetN(rstA), .vga(ifA)
    );

    vga_timing_gen #(.CLK_DIV(1), .PIPE_DELAY(3)) dutB (
        .clk(clk), .resetN(rstB), .vga(ifB)
    );

    // Tiny raster: H_TOTAL=14 (sync 10..12), V_TOTAL=8 (sync lines 5..6), 112 ticks/frame.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(3), .PIPE_DELAY(2)
    ) dutC (
        .clk(clk), .resetN(rstC), .vga(ifC)
    );

    int nCmp = 0;
    int nMis = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    int         hsLow, blankHi, firstHsX, fall1, fall2;
    logic       prevHs;
    logic [10:0] hx [3];
    int         firstVisX, alignErr;
    logic [3:0] firstG, col5G, col7G;
    logic       blankAfter;
    logic [2:0] c;
    int         t, sofCnt, sofT1, sofT2, sofBad, vsLow;

    initial begin
        rstA = 1'b0;
        rstB = 1'b0;
        rstC = 1'b0;
        ifA.RGBIn = 8'b10_101_011;
        ifB.RGBIn = 8'h00;
        ifC.RGBIn = 8'hFF;
        repeat (3) @(negedge clk);

        checkVal("rst_pixelX", ifA.pixelX, 0);
        checkVal("rst_pixelY", ifA.pixelY, 0);
        checkVal("rst_tick", ifA.pixelTick, 0);
        checkVal("rst_sof", ifA.startOfFrame, 0);
        checkVal("rst_hs", ifA.vgaHS, 1);
        checkVal("rst_vs", ifA.vgaVS, 1);
        checkVal("rst_blankN", ifA.blankN, 0);
        checkVal("rst_rgb", {ifA.vgaR, ifA.vgaG, ifA.vgaB}, 0);

        // ---------------- instance A: default timing, CLK_DIV=2, PIPE_DELAY=1
        rstA = 1'b1;
        @(negedge clk); checkVal("a_tick_clk1", ifA.pixelTick, 0);
        @(negedge clk); checkVal("a_tick_clk2", ifA.pixelTick, 1);
                        checkVal("a_x_clk2", ifA.pixelX, 0);
        @(negedge clk); checkVal("a_tick_clk3", ifA.pixelTick, 0);
                        checkVal("a_x_clk3", ifA.pixelX, 1);
        @(negedge clk); checkVal("a_tick_clk4", ifA.pixelTick, 1);
                        checkVal("a_x_clk4", ifA.pixelX, 1);
        // now in tick cycle 2; tick cycle k shows pixelX=(k-1)%800
        repeat (798) repeat (2) @(negedge clk);
        checkVal("a_x_799", ifA.pixelX, 799);
        checkVal("a_y_line0", ifA.pixelY, 0);
        repeat (2) @(negedge clk);
        checkVal("a_x_wrap", ifA.pixelX, 0);
        checkVal("a_y_line1", ifA.pixelY, 1);

        hsLow = 0; blankHi = 0; firstHsX = -1; fall1 = 0; fall2 = 0; prevHs = 1'b1;
        for (int k = 801; k <= 2460; k++) begin
            if (k > 801) repeat (2) @(negedge clk);
            if (k <= 1600) begin
                if (!ifA.vgaHS) hsLow++;
                if (ifA.blankN) blankHi++;
                if (!ifA.vgaHS && firstHsX < 0) firstHsX = int'(ifA.pixelX);
            end
            if (prevHs && !ifA.vgaHS) begin
                if (fall1 == 0) fall1 = k;
                else if (fall2 == 0) fall2 = k;
            end
            prevHs = ifA.vgaHS;
            if (k == 901) begin
                checkVal("a_vis_R", ifA.vgaR, 4'b1011);
                checkVal("a_vis_G", ifA.vgaG, 4'b0110);
                checkVal("a_vis_B", ifA.vgaB, 4'b1010);
            end
            if (k == 1503) begin
                checkVal("a_blank_blankN", ifA.blankN, 0);
                checkVal("a_blank_rgb", {ifA.vgaR, ifA.vgaG, ifA.vgaB}, 0);
            end
        end
        checkVal("a_hs_low_ticks", hsLow, 96);
        checkVal("a_blank_hi_ticks", blankHi, 640);
        checkVal("a_hs_fall_x", firstHsX, 658);
        checkVal("a_hs_fall_tick", fall1, 1459);
        checkVal("a_line_period", fall2 - fall1, 800);

        // mid-line reset at pixelX=300 (line 3, visible)
        repeat (241) repeat (2) @(negedge clk);
        checkVal("a_pre_rst_x", ifA.pixelX, 300);
        checkVal("a_pre_rst_blankN", ifA.blankN, 1);
        rstA = 1'b0;
        #1;
        checkVal("a_mid_rst_xy", {ifA.pixelX, ifA.pixelY}, 0);
        checkVal("a_mid_rst_sync", {ifA.vgaHS, ifA.vgaVS, ifA.blankN}, 3'b110);
        checkVal("a_mid_rst_rgb", {ifA.vgaR, ifA.vgaG, ifA.vgaB}, 0);
        @(negedge clk); rstA = 1'b1;
        @(negedge clk); checkVal("a_restart_tick1", ifA.pixelTick, 0);
        @(negedge clk); checkVal("a_restart_tick2", ifA.pixelTick, 1);
                        checkVal("a_restart_xy", {ifA.pixelX, ifA.pixelY}, 0);
        @(negedge clk); checkVal("a_restart_x1", ifA.pixelX, 1);

        // ---------------- instance B: CLK_DIV=1, PIPE_DELAY=3 colour alignment
        hx[0] = '0; hx[1] = '0; hx[2] = '0;
        firstVisX = -1; alignErr = 0; firstG = 4'hF; col5G = 4'h0; col7G = 4'h0; blankAfter = 1'b1;
        rstB = 1'b1;
        @(negedge clk);
        checkVal("b_tick_clk1", ifB.pixelTick, 1);
        for (int q = 0; q <= 700; q++) begin
            if (q > 0) @(negedge clk);
            if (q == 1) checkVal("b_tick_clk2", ifB.pixelTick, 1);
            ifB.RGBIn = {5'b00000, hx[2][2:0]};
            hx[2] = hx[1];
            hx[1] = hx[0];
            hx[0] = ifB.pixelX;
            if (ifB.blankN && firstVisX < 0) begin
                firstVisX = int'(ifB.pixelX);
                firstG = ifB.vgaG;
            end
            if (q == 9) col5G = ifB.vgaG;
            if (q == 11) col7G = ifB.vgaG;
            if (q >= 4 && q <= 643) begin
                c = 3'(q - 4);
                if (!ifB.blankN || ifB.vgaG !== {c, c[2]}) alignErr++;
            end
            if (q == 644) blankAfter = ifB.blankN;
        end
        checkVal("b_first_vis_x", firstVisX, 4);
        checkVal("b_col0_G", firstG, 4'b0000);
        checkVal("b_col5_G", col5G, 4'b1011);
        checkVal("b_col7_G", col7G, 4'b1111);
        checkVal("b_align_errors", alignErr, 0);
        checkVal("b_blank_after_640", blankAfter, 0);

        // ---------------- instance C: frame level on a tiny raster
        t = 0; sofCnt = 0; sofT1 = 0; sofT2 = 0; sofBad = 0; vsLow = 0;
        rstC = 1'b1;
        for (int i = 0; i < 672; i++) begin
            @(negedge clk);
            if (ifC.pixelTick) t++;
            if (ifC.startOfFrame) begin
                sofCnt++;
                if (!ifC.pixelTick || ifC.pixelX != 11'd13 || ifC.pixelY != 11'd7) sofBad++;
                if (sofT1 == 0) sofT1 = t;
                else if (sofT2 == 0) sofT2 = t;
            end
            if (ifC.pixelTick && t > 112 && !ifC.vgaVS) vsLow++;
            if (ifC.pixelTick && t == 113) checkVal("c_wrap_xy", {ifC.pixelX, ifC.pixelY}, 0);
        end
        checkVal("c_tick_count", t, 224);
        checkVal("c_sof_count", sofCnt, 2);
        checkVal("c_sof_first", sofT1, 112);
        checkVal("c_sof_period", sofT2 - sofT1, 112);
        checkVal("c_sof_position", sofBad, 0);
        checkVal("c_vs_low_ticks", vsLow, 28);

        // pins now showing pixel (10,5): inside both sync pulses
        repeat (84) repeat (3) @(negedge clk);
        checkVal("c_pre_rst_sync", {ifC.vgaHS, ifC.vgaVS, ifC.blankN}, 3'b000);
        rstC = 1'b0;
        #1;
        checkVal("c_mid_rst_sync", {ifC.vgaHS, ifC.vgaVS, ifC.blankN}, 3'b110);
        checkVal("c_mid_rst_xy", {ifC.pixelX, ifC.pixelY}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end

endmodule
